// File: rtl/md_unit_ctrl_if.sv
// E-stage <-> HI/LO unit signal bundle. The master is the E-stage decode/forwarding side,
// the slave is the multiply/divide sequencer.
interface md_unit_ctrl_if;
  logic        start;
  logic [2:0]  hilo_op;
  logic [1:0]  whilo;
  logic [1:0]  hilo_sel;
  logic        md_use;
  logic        flush;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  modport master (
    output start, hilo_op, whilo, hilo_sel, md_use, flush, rs_val, rt_val,
    input  busy, stall_md, hi, lo, rdata
  );

  modport slave (
    input  start, hilo_op, whilo, hilo_sel, md_use, flush, rs_val, rt_val,
    output busy, stall_md, hi, lo, rdata
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide sequencer: computes the result at issue, holds it as pending for a fixed
// latency, then commits it to HI/LO. Also services mthi/mtlo/mfhi/mflo and the E-stage stall.
module md_unit_ctrl #(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input logic           clk,
  input logic           reset,
  md_unit_ctrl_if.slave bus
);

  localparam int unsigned MaxCyc = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;

  logic              op_valid, is_div, is_signed, issue;
  logic signed [63:0] prod_s;
  logic [63:0]       prod_u, prod;
  logic              a_neg, b_neg, div_zero;
  logic [31:0]       a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign op_valid  = ~bus.hilo_op[2];
  assign is_div    = bus.hilo_op[1];
  assign is_signed = ~bus.hilo_op[0];
  assign issue     = bus.start & ~bus.flush & op_valid;

  always_comb begin
    prod_s = 64'($signed(bus.rs_val)) * 64'($signed(bus.rt_val));
    prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
    prod   = is_signed ? prod_s : prod_u;
  end

  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow case entirely.
  always_comb begin
    a_neg    = is_signed & bus.rs_val[31];
    b_neg    = is_signed & bus.rt_val[31];
    a_mag    = a_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
    b_mag    = b_neg ? (32'd0 - bus.rt_val) : bus.rt_val;
    div_zero = (bus.rt_val == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      StIdle: begin
        if (issue) begin
          if (is_div) begin
            state_d   = StDiv;
            count_d   = CntW'(DIV_CYC);
            pend_hi_d = rem;
            pend_lo_d = quot;
            pend_wr_d = ~div_zero;
          end else begin
            state_d   = StMul;
            count_d   = CntW'(MUL_CYC);
            pend_hi_d = prod[63:32];
            pend_lo_d = prod[31:0];
            pend_wr_d = 1'b1;
          end
        end else if (~bus.start & ~bus.flush) begin
          if (bus.whilo == 2'b00) hi_d = bus.rs_val;
          else if (bus.whilo == 2'b01) lo_d = bus.rs_val;
        end
      end
      StMul, StDiv: begin
        count_d = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          state_d = StIdle;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    bus.busy     = (state_q != StIdle);
    bus.stall_md = bus.md_use & (bus.busy | bus.start);
    bus.hi       = hi_q;
    bus.lo       = lo_q;
    case (bus.hilo_sel)
      2'b00:   bus.rdata = hi_q;
      2'b01:   bus.rdata = lo_q;
      default: bus.rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: stimulus pushes expected {busy length, hi, lo} per operation;
// a monitor pops and compares each time busy falls.
module tb_md_unit_ctrl;

  logic clk;
  logic reset;
  md_unit_ctrl_if bus ();

  md_unit_ctrl #(.MUL_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles at each negedge and checks results when busy drops.
  initial begin
    int   run_len;
    logic prev_busy;
    exp_t e;
    run_len   = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) run_len++;
      else if (prev_busy) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_len"}, run_len, e.len);
          check({e.tag, "_hi"}, bus.hi, e.hi);
          check({e.tag, "_lo"}, bus.lo, e.lo);
        end
        run_len = 0;
      end
      prev_busy = (bus.busy === 1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 50) begin
      step();
      k++;
    end
    if (bus.busy !== 1'b0) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic push(input string tag, input int len, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.tag = tag;
    e.len = len;
    e.hi  = h;
    e.lo  = l;
    sb.push_back(e);
  endtask

  // Drive start for one edge; caller sets side signals (flush/whilo) for the busy phase.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    step();
    bus.start   = 1'b1;
    bus.hilo_op = op;
    bus.rs_val  = rs;
    bus.rt_val  = rt;
    step();
    bus.start   = 1'b0;
    bus.hilo_op = 3'b111;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.hilo_op  = 3'b111;
    bus.whilo    = 2'b11;
    bus.hilo_sel = 2'b11;
    bus.md_use   = 1'b0;
    bus.flush    = 1'b0;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    reset        = 1'b0;
    step();
    step();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_stall", bus.stall_md, 1'b0);
    reset = 1'b1;
    step();

    push("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult");
    push("multu", 5, 32'h0000_0002, 32'hFFFF_FFFA);
    issue(3'b001, 32'hFFFF_FFFE, 32'd3);
    wait_idle("multu");
    push("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div");
    push("divu_zero", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'b011, 32'd7, 32'd0);
    wait_idle("divu_zero");
    push("div_ovf", 10, 32'h0000_0000, 32'h8000_0000);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");
    push("div_negdiv", 10, 32'h0000_0001, 32'hFFFF_FFFD);
    issue(3'b010, 32'd7, 32'hFFFF_FFFE);
    wait_idle("div_negdiv");
    push("divu", 10, 32'd2, 32'd14);
    issue(3'b011, 32'd100, 32'd7);
    wait_idle("divu");

    // Back-to-back mult followed by an mflo held in E.
    push("mult_b2b", 5, 32'd0, 32'h0000_0019);
    step();
    bus.start   = 1'b1;
    bus.hilo_op = 3'b000;
    bus.rs_val  = 32'd5;
    bus.rt_val  = 32'd5;
    bus.md_use  = 1'b1;
    #2 check("stall_issue", bus.stall_md, 1'b1);
    step();
    bus.start    = 1'b0;
    bus.hilo_op  = 3'b111;
    bus.hilo_sel = 2'b01;
    for (int i = 0; i < 5; i++) begin
      check("stall_busy", bus.stall_md, 1'b1);
      step();
    end
    check("stall_release", bus.stall_md, 1'b0);
    check("mflo_rdata", bus.rdata, 32'h0000_0019);
    bus.md_use   = 1'b0;
    bus.hilo_sel = 2'b00;
    #1 check("mfhi_rdata", bus.rdata, 32'd0);
    bus.hilo_sel = 2'b11;
    #1 check("rdata_none", bus.rdata, 32'd0);

    // mthi in idle
    bus.whilo  = 2'b00;
    bus.rs_val = 32'h0000_1234;
    step();
    bus.whilo = 2'b11;
    check("mthi_hi", bus.hi, 32'h0000_1234);
    check("mthi_lo", bus.lo, 32'h0000_0019);

    // mtlo while busy is dropped
    push("mult_mtlo", 5, 32'd1, 32'd0);
    issue(3'b000, 32'h0001_0000, 32'h0001_0000);
    bus.whilo  = 2'b01;
    bus.rs_val = 32'h0000_DEAD;
    wait_idle("mult_mtlo");
    bus.whilo = 2'b11;
    step();
    check("mtlo_busy_lo", bus.lo, 32'd0);

    // start with flush: no issue, no write
    step();
    bus.start   = 1'b1;
    bus.flush   = 1'b1;
    bus.hilo_op = 3'b000;
    bus.rs_val  = 32'd9;
    bus.rt_val  = 32'd9;
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 1'b0);
    check("flush_hi", bus.hi, 32'd1);
    check("flush_lo", bus.lo, 32'd0);

    // invalid op with start, plus an mthi that start must override
    bus.start   = 1'b1;
    bus.hilo_op = 3'b100;
    bus.whilo   = 2'b00;
    bus.rs_val  = 32'h0000_BEEF;
    step();
    bus.start = 1'b0;
    bus.whilo = 2'b11;
    check("inv_busy", bus.busy, 1'b0);
    check("inv_hi", bus.hi, 32'd1);

    // flush during busy still commits
    push("mult_flush", 5, 32'd0, 32'd42);
    issue(3'b000, 32'd6, 32'd7);
    bus.flush = 1'b1;
    wait_idle("mult_flush");
    bus.flush = 1'b0;

    // reset in the third busy cycle of a div
    push("div_rst", 2, 32'd0, 32'd0);
    issue(3'b010, 32'd100, 32'd7);
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_hi", bus.hi, 32'd0);
    check("rst_mid_lo", bus.lo, 32'd0);
    step();
    reset = 1'b1;
    push("mult_after_rst", 5, 32'd0, 32'd1);
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("mult_after_rst");

    step();
    step();
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
